// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master bridge and its address decoder.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

   // Select-field width; a single slave still gets one select bit.
   function automatic int sel_w(input int num_slv);
      return (num_slv <= 2) ? 1 : $clog2(num_slv);
   endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Command port plus APB bus of the N-slave master bridge.
// valid/ready: a command transfers on a rising edge where req_valid and req_ready are both high; the requester keeps it stable until then.
interface apb_master_nslv_if
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8
);
   localparam int SEL_W = sel_w(NUM_SLV);
   localparam int PA_W  = ADDR_W - SEL_W;

   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_W-1:0]         req_addr;
   logic [DATA_W-1:0]         req_wdata;
   logic                      rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;
   logic [NUM_SLV-1:0]        PSEL;
   logic                      PENABLE;
   logic                      PWRITE;
   logic [PA_W-1:0]           PADDR;
   logic [DATA_W-1:0]         PWDATA;
   logic [NUM_SLV*DATA_W-1:0] PRDATA;
   logic [NUM_SLV-1:0]        PREADY;
   logic [NUM_SLV-1:0]        PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

endinterface

// File: rtl/apb_addr_decode.sv
// Slave-select decoder: select field to one-hot PSEL mask, flagging selects with no slave behind them.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int SEL_W   = sel_w(NUM_SLV)
) (
   input  logic [SEL_W-1:0]   sel,
   output logic [NUM_SLV-1:0] psel_mask,
   output logic               miss
);

   always_comb begin
      psel_mask = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         psel_mask[k] = (sel == SEL_W'(k));
      end
      // One extra bit so NUM_SLV = 16 still fits the comparison.
      miss = ({1'b0, sel} >= (SEL_W+1)'(NUM_SLV));
   end

endmodule

// File: rtl/apb_master_nslv.sv
// APB master bridge: one command at a time run as SETUP/ACCESS to one of NUM_SLV slaves,
// with wait states, slave errors, decode-miss errors and a bounded ACCESS timeout.
module apb_master_nslv
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   apb_master_nslv_if.master    bus,
   output apb_state_t           dbg_state
);

   localparam int SEL_W = sel_w(NUM_SLV);
   localparam int PA_W  = ADDR_W - SEL_W;
   localparam int CNT_W = $clog2(TIMEOUT);

   apb_state_t         state;
   logic [CNT_W-1:0]   wait_cnt;
   logic [NUM_SLV-1:0] dec_mask;
   logic               dec_miss;
   logic               accept;
   logic               sel_ready;
   logic               sel_err;
   logic [DATA_W-1:0]  sel_rdata;

   apb_addr_decode #(
      .NUM_SLV (NUM_SLV),
      .SEL_W   (SEL_W)
   ) u_dec (
      .sel       (bus.req_addr[ADDR_W-1 -: SEL_W]),
      .psel_mask (dec_mask),
      .miss      (dec_miss)
   );

   // Slave responses are muxed by the registered PSEL, so unselected slaves never leak in.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (bus.PSEL[k]) begin
            sel_ready = sel_ready | bus.PREADY[k];
            sel_err   = sel_err   | bus.PSLVERR[k];
            sel_rdata = sel_rdata | bus.PRDATA[k*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.req_ready = PRESETn && (state == IDLE);
   assign accept        = bus.req_valid && bus.req_ready;
   assign dbg_state     = state;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         bus.PSEL      <= '0;
         bus.PENABLE   <= 1'b0;
         bus.PWRITE    <= 1'b0;
         bus.PADDR     <= '0;
         bus.PWDATA    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= RSP_OK;
         bus.rsp_rdata <= '0;
      end else begin
         // Response fields are zero outside the single-cycle pulse.
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= RSP_OK;
         bus.rsp_rdata <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dec_miss) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= RSP_ERR;
                  end else begin
                     state      <= SETUP;
                     bus.PSEL   <= dec_mask;
                     bus.PWRITE <= bus.req_write;
                     bus.PADDR  <= bus.req_addr[PA_W-1:0];
                     bus.PWDATA <= bus.req_wdata;
                  end
               end
            end
            SETUP: begin
               state       <= ACCESS;
               bus.PENABLE <= 1'b1;
               wait_cnt    <= '0;
            end
            ACCESS: begin
               // PREADY wins over the timeout in the last allowed cycle.
               if (sel_ready) begin
                  state         <= IDLE;
                  bus.PSEL      <= '0;
                  bus.PENABLE   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= sel_err;
                  if (!bus.PWRITE && !sel_err) begin
                     bus.rsp_rdata <= sel_rdata;
                  end
               end else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
                  state         <= IDLE;
                  bus.PSEL      <= '0;
                  bus.PENABLE   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= RSP_ERR;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: directed vector table, randomized transfers against a latency/response
// model, decode miss on a three-slave instance, reset mid-transfer and back-to-back throughput.
module tb_apb_master_nslv;
   import apb_pkg::*;

   localparam int NUM_SLV = 4;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;
   localparam int W       = DATA_W + 1;

   // ---------------- clock / reset ----------------
   logic PCLK    = 1'b0;
   logic PRESETn = 1'b0;
   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   apb_master_nslv_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   apb_master_nslv_if #(.NUM_SLV(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();
   apb_state_t dbg_state;
   apb_state_t dbg_state3;

   apb_master_nslv #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   apb_master_nslv #(.NUM_SLV(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut3 (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .bus       (bus3),
      .dbg_state (dbg_state3)
   );

   // ---------------- slave models ----------------
   int                wait_cfg  [NUM_SLV];
   logic [DATA_W-1:0] rdata_cfg [NUM_SLV];
   logic              err_cfg   [NUM_SLV];
   int                acc_cnt = 0;

   always @(posedge PCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

   // Unselected slaves answer ready with an error and their own data, all of which must be ignored.
   always_comb begin
      for (int k = 0; k < NUM_SLV; k++) begin
         bus.PREADY[k]                   = bus.PSEL[k] ? (bus.PENABLE && (acc_cnt >= wait_cfg[k])) : 1'b1;
         bus.PSLVERR[k]                  = err_cfg[k];
         bus.PRDATA[k*DATA_W +: DATA_W]  = rdata_cfg[k];
      end
   end

   assign bus3.PREADY  = '1;
   assign bus3.PSLVERR = '0;
   assign bus3.PRDATA  = '0;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   logic [W-1:0] exp_q[$];
   int           rsp_cyc_q[$];

   always @(negedge PCLK) begin : scoreboard
      logic [W-1:0] e;
      if (PRESETn && bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("rsp_err_rdata", 32'({bus.rsp_err, bus.rsp_rdata}), 32'(e));
         end
         rsp_cyc_q.push_back(cyc);
      end
   end

   // Reference: W wait states complete after 3+W cycles unless W reaches TIMEOUT,
   // in which case the abort lands after TIMEOUT ACCESS cycles with an error.
   function automatic logic [W-1:0] model_rsp(input logic wr, input logic slverr,
                                               input logic [DATA_W-1:0] rd, input int wt,
                                               output int lat);
      if (wt > TIMEOUT - 1) begin
         lat = TIMEOUT + 2;
         return {1'b1, {DATA_W{1'b0}}};
      end
      lat = 3 + wt;
      return {slverr, (wr || slverr) ? {DATA_W{1'b0}} : rd};
   endfunction

   // ---------------- driver ----------------
   task automatic run_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input int exp_lat, input string tag);
      int lat;
      int guard;
      logic [NUM_SLV-1:0] exp_psel;
      exp_psel = NUM_SLV'(1) << addr[ADDR_W-1 -: 2];
      @(negedge PCLK);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(negedge PCLK);
         guard++;
      end
      check({tag, "_ready"}, 32'(bus.req_ready), 32'(1));
      @(posedge PCLK);
      @(negedge PCLK);
      bus.req_valid = 1'b0;
      lat = 1;
      check({tag, "_setup_psel"}, 32'(bus.PSEL), 32'(exp_psel));
      check({tag, "_setup_penable"}, 32'(bus.PENABLE), 32'(0));
      check({tag, "_setup_paddr"}, 32'(bus.PADDR), 32'(addr[7:0]));
      check({tag, "_setup_pwrite"}, 32'(bus.PWRITE), 32'(wr));
      if (wr) check({tag, "_setup_pwdata"}, 32'(bus.PWDATA), 32'(wd));
      while (!bus.rsp_valid && lat < 60) begin
         @(negedge PCLK);
         lat++;
         if (lat == 2) begin
            check({tag, "_access_penable"}, 32'(bus.PENABLE), 32'(1));
            check({tag, "_access_psel"}, 32'(bus.PSEL), 32'(exp_psel));
            check({tag, "_access_paddr"}, 32'(bus.PADDR), 32'(addr[7:0]));
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic set_slaves(input int tgt, input int wt, input logic [DATA_W-1:0] prd, input logic se);
      for (int k = 0; k < NUM_SLV; k++) begin
         wait_cfg[k]  = 0;
         err_cfg[k]   = 1'b1;
         rdata_cfg[k] = DATA_W'($urandom_range(0, 255));
      end
      wait_cfg[tgt]  = wt;
      rdata_cfg[tgt] = prd;
      err_cfg[tgt]   = se;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                wt;
      logic [DATA_W-1:0] prd;
      logic              slverr;
      logic              exp_err;
      logic [DATA_W-1:0] exp_rdata;
      int                exp_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic              r_wr;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_wd;
      logic [DATA_W-1:0] r_prd;
      logic              r_se;
      int                r_wt;
      int                r_lat;
      logic [W-1:0]      r_exp;
      int                guard;

      vecs[0] = '{1'b1, 10'h105, 8'h2A, 0,   8'h00, 1'b0, 1'b0, 8'h00, 3};
      vecs[1] = '{1'b0, 10'h2C3, 8'h00, 3,   8'h5C, 1'b0, 1'b0, 8'h5C, 6};
      vecs[2] = '{1'b1, 10'h3AA, 8'h11, 0,   8'h00, 1'b1, 1'b1, 8'h00, 3};
      vecs[3] = '{1'b0, 10'h011, 8'h00, 15,  8'hA5, 1'b0, 1'b0, 8'hA5, 18};
      vecs[4] = '{1'b0, 10'h200, 8'h00, 255, 8'h99, 1'b0, 1'b1, 8'h00, 18};
      vecs[5] = '{1'b0, 10'h3FF, 8'h00, 1,   8'h77, 1'b1, 1'b1, 8'h00, 4};
      vecs[6] = '{1'b0, 10'h100, 8'h00, 2,   8'hFF, 1'b0, 1'b0, 8'hFF, 5};

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus3.req_valid = 1'b0;
      bus3.req_write = 1'b0;
      bus3.req_addr  = '0;
      bus3.req_wdata = '0;
      set_slaves(0, 0, 8'h00, 1'b0);

      // Reset state
      PRESETn = 1'b0;
      repeat (3) @(negedge PCLK);
      check("rst_psel", 32'(bus.PSEL), 32'(0));
      check("rst_penable", 32'(bus.PENABLE), 32'(0));
      check("rst_pwrite", 32'(bus.PWRITE), 32'(0));
      check("rst_paddr", 32'(bus.PADDR), 32'(0));
      check("rst_pwdata", 32'(bus.PWDATA), 32'(0));
      check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'(0));
      check("rst_req_ready_low", 32'(bus.req_ready), 32'(0));
      PRESETn = 1'b1;
      @(negedge PCLK);
      check("rst_req_ready_high", 32'(bus.req_ready), 32'(1));
      check("rst_state", 32'(dbg_state), 32'(IDLE));

      // Directed table
      for (int i = 0; i < 7; i++) begin
         set_slaves(int'(vecs[i].addr[9:8]), vecs[i].wt, vecs[i].prd, vecs[i].slverr);
         exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
         run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_lat, $sformatf("vec%0d", i));
      end

      // Randomized transfers against the model
      for (int i = 0; i < 40; i++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = ADDR_W'($urandom_range(0, 1023));
         r_wd   = DATA_W'($urandom_range(0, 255));
         r_prd  = DATA_W'($urandom_range(0, 255));
         r_se   = ($urandom_range(0, 3) == 0);
         r_wt   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 4));
         set_slaves(int'(r_addr[9:8]), r_wt, r_prd, r_se);
         r_exp = model_rsp(r_wr, r_se, r_prd, r_wt, r_lat);
         exp_q.push_back(r_exp);
         run_xfer(r_wr, r_addr, r_wd, r_lat, $sformatf("rnd%0d", i));
      end

      // Decode miss on the three-slave instance
      @(negedge PCLK);
      bus3.req_valid = 1'b1;
      bus3.req_write = 1'b0;
      bus3.req_addr  = 10'h3F0;
      @(posedge PCLK);
      @(negedge PCLK);
      bus3.req_valid = 1'b0;
      check("miss_rsp_valid", 32'(bus3.rsp_valid), 32'(1));
      check("miss_rsp_err", 32'(bus3.rsp_err), 32'(1));
      check("miss_rsp_rdata", 32'(bus3.rsp_rdata), 32'(0));
      check("miss_psel", 32'(bus3.PSEL), 32'(0));
      check("miss_req_ready", 32'(bus3.req_ready), 32'(1));
      @(negedge PCLK);
      check("miss_pulse_end", 32'(bus3.rsp_valid), 32'(0));
      check("miss_psel_after", 32'(bus3.PSEL), 32'(0));
      bus3.req_valid = 1'b1;
      bus3.req_write = 1'b1;
      bus3.req_addr  = 10'h2F0;
      bus3.req_wdata = 8'h33;
      @(posedge PCLK);
      @(negedge PCLK);
      bus3.req_valid = 1'b0;
      check("slv3_setup_psel", 32'(bus3.PSEL), 32'(3'b100));
      check("slv3_setup_paddr", 32'(bus3.PADDR), 32'(8'hF0));
      check("slv3_setup_pwdata", 32'(bus3.PWDATA), 32'(8'h33));
      repeat (2) @(negedge PCLK);
      check("slv3_rsp_valid", 32'(bus3.rsp_valid), 32'(1));
      check("slv3_rsp_err", 32'(bus3.rsp_err), 32'(0));

      // Reset in the middle of ACCESS
      set_slaves(2, 1000, 8'h42, 1'b0);
      @(negedge PCLK);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 10'h2C3;
      @(posedge PCLK);
      @(negedge PCLK);
      bus.req_valid = 1'b0;
      guard = 0;
      while (!bus.PENABLE && guard < 10) begin
         @(negedge PCLK);
         guard++;
      end
      repeat (2) @(negedge PCLK);
      check("midrst_in_access", 32'(bus.PENABLE), 32'(1));
      PRESETn = 1'b0;
      @(negedge PCLK);
      check("midrst_psel", 32'(bus.PSEL), 32'(0));
      check("midrst_penable", 32'(bus.PENABLE), 32'(0));
      check("midrst_paddr", 32'(bus.PADDR), 32'(0));
      check("midrst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'(0));
      PRESETn = 1'b1;
      repeat (4) @(negedge PCLK);
      check("midrst_ready", 32'(bus.req_ready), 32'(1));
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      check("midrst_psel_after", 32'(bus.PSEL), 32'(0));

      // Back-to-back zero-wait writes
      set_slaves(0, 0, 8'h00, 1'b0);
      for (int k = 0; k < NUM_SLV; k++) err_cfg[k] = 1'b0;
      rsp_cyc_q.delete();
      @(negedge PCLK);
      for (int i = 0; i < 8; i++) begin
         bus.req_valid = 1'b1;
         bus.req_write = 1'b1;
         bus.req_addr  = {2'(i), 8'(i * 3)};
         bus.req_wdata = 8'(8'hC0 + i);
         exp_q.push_back({1'b0, {DATA_W{1'b0}}});
         guard = 0;
         while (!bus.req_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
         end
         @(posedge PCLK);
         @(negedge PCLK);
      end
      bus.req_valid = 1'b0;
      guard = 0;
      while (rsp_cyc_q.size() < 8 && guard < 40) begin
         @(negedge PCLK);
         guard++;
      end
      check("b2b_rsp_count", 32'(rsp_cyc_q.size()), 32'(8));
      for (int i = 1; i < rsp_cyc_q.size(); i++) begin
         check($sformatf("b2b_spacing%0d", i), 32'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 32'(3));
      end

      repeat (3) @(negedge PCLK);
      check("queue_drain", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
